lifo_arbiter: RTL and testbench
===============================

LIFO_ARBITER -- requirements
Module: lifo_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of requesters and stack.
REQ-002 SHALL have parameter DEPTH, default 8, stack depth; used only for the occupancy output width, which is clog2(DEPTH+1) bits.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports req0_valid and req1_valid  input  1 each  requester N presents an operation.
REQ-006 SHALL have ports req0_op and req1_op  input  1 each  1 = push, 0 = pop.
REQ-007 SHALL have ports req0_data and req1_data  input  WIDTH each  push data.
REQ-008 SHALL have ports req0_ready and req1_ready  output  1 each  grant; the operation transfers when valid and ready are both high.
REQ-009 SHALL have ports rsp0_valid and rsp1_valid  output  1 each  completion strobe for requester N.
REQ-010 SHALL have ports rsp0_err and rsp1_err  output  1 each  operation rejected (push when full, pop when empty).
REQ-011 SHALL have port rsp_data  output  WIDTH  pop result, shared, meaningful only with a non-error pop rsp.
REQ-012 SHALL have ports lifo_push and lifo_pop  output  1 each  drive the stack.
REQ-013 SHALL have port lifo_din  output  WIDTH  stack write data.
REQ-014 SHALL have ports lifo_empty, lifo_full  input  1 each, and lifo_dout  input  WIDTH  from the stack.
REQ-015 SHALL have port occupancy  output  clog2(DEPTH+1)  shadow count of stacked entries.

Function
REQ-016 Stack contract: lifo_push/lifo_pop sampled at rising edge; lifo_dout, lifo_empty and lifo_full update at that same edge.
REQ-017 SHALL grant at most one requester per cycle; reqN_ready is combinational from the valid inputs and last_grant.
REQ-018 One valid requester: that requester is granted.
REQ-019 Both valid: the requester other than last_grant is granted (round-robin).
REQ-020 last_grant SHALL update to the granted index on every transfer and hold otherwise.
REQ-021 A granted request SHALL always transfer, so a valid request waits at most one cycle behind the other requester.
REQ-022 Granted push with lifo_full=0: lifo_push=1 and lifo_din=reqN_data in the same cycle.
REQ-023 Granted pop with lifo_empty=0: lifo_pop=1 in the same cycle.
REQ-024 lifo_push and lifo_pop SHALL never be high together, and SHALL be 0 when no transfer occurs; lifo_din SHALL be 0 when lifo_push=0.
REQ-025 Granted push with lifo_full=1, or pop with lifo_empty=1: SHALL issue nothing to the stack and SHALL flag an error.
REQ-026 Response timing: rspN_valid SHALL pulse for exactly one cycle, in the cycle after the transfer (registered), with rspN_err registered alongside it.
REQ-027 During a non-error pop response, rsp_data SHALL equal lifo_dout; otherwise rsp_data SHALL be 0.
REQ-028 occupancy SHALL increment on an issued push and decrement on an issued pop, so it never leaves the range 0..DEPTH.
REQ-029 Back-to-back transfers every cycle SHALL be supported with no bubble, including alternating push/pop between requesters.
REQ-030 A request whose valid drops before grant SHALL be ignored with no response.

Reset
REQ-031 rstn low SHALL immediately and asynchronously clear: last_grant=1 (so req0 wins the first tie), rsp0/1_valid=0, rsp0/1_err=0, occupancy=0.
REQ-032 rstn low SHALL force combinational outputs inactive: req0/1_ready=0, lifo_push=0, lifo_pop=0, lifo_din=0, rsp_data=0.
REQ-033 Reset asserted mid-operation SHALL discard any pending response; no rsp pulse SHALL follow reset release.
REQ-034 The stack SHALL be reset by the same system reset; this block does not sequence the stack's reset.

Verification
REQ-035 Single push: req0 push 0xA5 from reset -> lifo_push=1, lifo_din=0xA5 that cycle; rsp0_valid=1, rsp0_err=0 next cycle; occupancy=1.
REQ-036 LIFO order via arbiter: req1 pushes 0x11 then 0x22, then pops twice -> rsp_data 0x22 then 0x11, each with rsp1_valid; occupancy back to 0.
REQ-037 Contention: both valid every cycle, all pushes, from reset -> grant order 0,1,0,1; each rsp in the cycle after its grant.
REQ-038 Boundary: pop on empty -> rsp_err=1, lifo_pop=0. Nine pushes with DEPTH=8 -> ninth gets rsp_err=1, lifo_push=0, occupancy stays 8.
REQ-039 Reset mid-traffic: rstn low in the cycle after a transfer -> rsp valid clears without waiting for an edge; after release req0 wins the first tie.
REQ-040 Stack interface check: every cycle assert !(lifo_push && lifo_pop), and assert occupancy==0 iff lifo_empty and occupancy==DEPTH iff lifo_full.

Source files
------------

// File: rtl/lifo_arbiter.sv
// Two-requester round-robin front end for an external LIFO stack.
// Grants one push/pop per cycle, answers each transfer one cycle later and tracks occupancy.
module lifo_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           req0_valid,
  input  logic                           req0_op,
  input  logic [WIDTH-1:0]               req0_data,
  output logic                           req0_ready,
  input  logic                           req1_valid,
  input  logic                           req1_op,
  input  logic [WIDTH-1:0]               req1_data,
  output logic                           req1_ready,
  output logic                           rsp0_valid,
  output logic                           rsp0_err,
  output logic                           rsp1_valid,
  output logic                           rsp1_err,
  output logic [WIDTH-1:0]               rsp_data,
  output logic                           lifo_push,
  output logic                           lifo_pop,
  output logic [WIDTH-1:0]               lifo_din,
  input  logic                           lifo_empty,
  input  logic                           lifo_full,
  input  logic [WIDTH-1:0]               lifo_dout,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  logic             last_grant_q, last_grant_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp0_err_q, rsp0_err_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic             rsp1_err_q, rsp1_err_d;
  logic             pop_rsp_q, pop_rsp_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic             grant0, grant1, xfer, sel_op, push_ok, pop_ok, op_err;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    // Grants are held off while in reset so nothing reaches the stack.
    grant0   = rstn & req0_valid & (~req1_valid | last_grant_q);
    grant1   = rstn & req1_valid & (~req0_valid | ~last_grant_q);
    xfer     = grant0 | grant1;
    sel_op   = grant0 ? req0_op : req1_op;
    sel_data = grant0 ? req0_data : req1_data;
    push_ok  = xfer & sel_op & ~lifo_full;
    pop_ok   = xfer & ~sel_op & ~lifo_empty;
    op_err   = xfer & ~(push_ok | pop_ok);

    last_grant_d = xfer ? grant1 : last_grant_q;
    rsp0_valid_d = grant0;
    rsp0_err_d   = grant0 & op_err;
    rsp1_valid_d = grant1;
    rsp1_err_d   = grant1 & op_err;
    pop_rsp_d    = pop_ok;

    occ_d = occ_q;
    if (push_ok) begin
      occ_d = occ_q + OCC_ONE;
    end else if (pop_ok) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_err_q   <= 1'b0;
      pop_rsp_q    <= 1'b0;
      occ_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_err_q   <= rsp1_err_d;
      pop_rsp_q    <= pop_rsp_d;
      occ_q        <= occ_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign lifo_push  = push_ok;
  assign lifo_pop   = pop_ok;
  assign lifo_din   = push_ok ? sel_data : '0;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_err   = rsp1_err_q;
  // The stack presents the popped word on lifo_dout in the cycle after the pop.
  assign rsp_data   = (rstn & pop_rsp_q) ? lifo_dout : '0;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Bench for lifo_arbiter with a behavioural stack, a vector table and a response scoreboard.
module tb_lifo_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk, rstn;
  logic req0_valid, req0_op, req1_valid, req1_op;
  logic [7:0] req0_data, req1_data;
  logic req0_ready, req1_ready;
  logic rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp_data;
  logic lifo_push, lifo_pop, lifo_empty, lifo_full;
  logic [7:0] lifo_din, lifo_dout;
  logic [3:0] occupancy;

  lifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
    .rsp_data(rsp_data), .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_din(lifo_din),
    .lifo_empty(lifo_empty), .lifo_full(lifo_full), .lifo_dout(lifo_dout),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: popped word appears on lifo_dout at the pop edge.
  logic [7:0] stk_mem [DEPTH];
  int         stk_cnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stk_cnt   <= 0;
      lifo_dout <= 8'h00;
    end else if (lifo_push && stk_cnt < DEPTH) begin
      stk_mem[stk_cnt] <= lifo_din;
      stk_cnt          <= stk_cnt + 1;
    end else if (lifo_pop && stk_cnt > 0) begin
      lifo_dout <= stk_mem[stk_cnt-1];
      stk_cnt   <= stk_cnt - 1;
    end
  end
  assign lifo_empty = (stk_cnt == 0);
  assign lifo_full  = (stk_cnt == DEPTH);

  typedef struct {
    logic       v0, op0;
    logic [7:0] d0;
    logic       v1, op1;
    logic [7:0] d1;
    logic [3:0] exp;   // {ready0, ready1, lifo_push, lifo_pop}
  } vec_t;

  typedef struct packed {
    logic       v0, v1, e0, e1;
    logic [7:0] data;
  } rsp_t;

  int         checks = 0;
  int         errors = 0;
  logic       run_mon = 1'b0;
  rsp_t       sb[$];
  logic [7:0] ref_q[$];
  vec_t       vecs[$];

  function automatic vec_t mk(logic v0, logic op0, logic [7:0] d0,
                              logic v1, logic op1, logic [7:0] d1, logic [3:0] exp);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.d0 = d0;
    v.v1 = v1; v.op1 = op1; v.d1 = d1;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a falling edge: check last cycle's response, drive, check grant, predict response.
  task automatic step(input vec_t v, input string tag);
    rsp_t       e, n;
    logic       g1, op, err;
    logic [7:0] d;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    chk({tag, ":rsp"}, 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp_data}), 32'(e));
    chk({tag, ":occ"}, 32'(occupancy), 32'(ref_q.size()));
    req0_valid = v.v0; req0_op = v.op0; req0_data = v.d0;
    req1_valid = v.v1; req1_op = v.op1; req1_data = v.d1;
    #1;
    chk({tag, ":ready"}, 32'({req0_ready, req1_ready}), 32'(v.exp[3:2]));
    chk({tag, ":pushpop"}, 32'({lifo_push, lifo_pop}), 32'(v.exp[1:0]));
    g1 = v.exp[2];
    op = g1 ? v.op1 : v.op0;
    d  = g1 ? v.d1 : v.d0;
    chk({tag, ":din"}, 32'(lifo_din), v.exp[1] ? 32'(d) : 32'd0);
    n = '0;
    err = 1'b0;
    if (v.exp[3] | v.exp[2]) begin
      n.v0 = v.exp[3];
      n.v1 = v.exp[2];
      if (op) begin
        if (ref_q.size() >= DEPTH) err = 1'b1;
        else ref_q.push_back(d);
      end else begin
        if (ref_q.size() == 0) err = 1'b1;
        else n.data = ref_q.pop_back();
      end
      n.e0 = n.v0 & err;
      n.e1 = n.v1 & err;
    end
    sb.push_back(n);
    $display("txn %s r0=%b r1=%b push=%b pop=%b din=%h exp_err=%b depth=%0d",
             tag, req0_ready, req1_ready, lifo_push, lifo_pop, lifo_din, err, ref_q.size());
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (run_mon) begin
      chk("mon_excl", 32'(lifo_push & lifo_pop), 32'd0);
      chk("mon_empty", 32'(occupancy == 4'd0), 32'(lifo_empty));
      chk("mon_full", 32'(occupancy == 4'(DEPTH)), 32'(lifo_full));
    end
  end

  initial begin
    rsp_t e;
    // Inputs push/pop/grant patterns; expected {r0,r1,push,pop} derived by hand.
    vecs.push_back(mk(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 4'b1010));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 4'b0110));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 4'b0110));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0101));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0101));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b1001));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b1000));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0100));
    vecs.push_back(mk(1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 8'h02, 4'b1010));
    vecs.push_back(mk(1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 8'h04, 4'b0110));
    vecs.push_back(mk(1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 8'h06, 4'b1010));
    vecs.push_back(mk(1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 8'h08, 4'b0110));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h09, 4'b1001));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h09, 4'b0110));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0101));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000));

    // Reset state with a request pending on the inputs.
    rstn = 1'b0;
    req0_valid = 1'b1; req0_op = 1'b1; req0_data = 8'h5A;
    req1_valid = 1'b1; req1_op = 1'b1; req1_data = 8'h6B;
    #1;
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_pushpop", 32'({lifo_push, lifo_pop}), 32'd0);
    chk("rst_din", 32'(lifo_din), 32'd0);
    chk("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp_data}), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    run_mon = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while a response is on the outputs: it must vanish at once.
    step(mk(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 4'b1010), "pre_rst");
    e = sb.pop_front();
    chk("mid_rsp_before", 32'({rsp0_valid, rsp0_err}), 32'({e.v0, e.e0}));
    rstn = 1'b0;
    #1;
    chk("mid_rsp_cleared", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp_data}), 32'd0);
    chk("mid_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("mid_pushpop_din", 32'({lifo_push, lifo_pop, lifo_din}), 32'd0);
    chk("mid_occ", 32'(occupancy), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    sb.delete();
    ref_q.delete();
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    // Contention from reset: 0,1,0,1 with responses one cycle behind.
    step(mk(1'b1, 1'b1, 8'hB1, 1'b1, 1'b1, 8'hB2, 4'b1010), "cont0");
    step(mk(1'b1, 1'b1, 8'hB3, 1'b1, 1'b1, 8'hB4, 4'b0110), "cont1");
    step(mk(1'b1, 1'b1, 8'hB5, 1'b1, 1'b1, 8'hB6, 4'b1010), "cont2");
    step(mk(1'b1, 1'b1, 8'hB7, 1'b1, 1'b1, 8'hB8, 4'b0110), "cont3");
    step(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000), "cont_idle");

    // Fill to DEPTH, overflow once, then drain through the other requester.
    for (int i = 0; i < 16 && ref_q.size() < DEPTH; i++) begin
      step(mk(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 8'h00, 4'b1010), $sformatf("fill%0d", i));
    end
    step(mk(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, 4'b1000), "overflow");
    step(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000), "full_idle");
    for (int i = 0; i < DEPTH; i++) begin
      step(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0101), $sformatf("drain%0d", i));
    end
    step(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0100), "underflow");
    step(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000), "end_idle0");
    step(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000), "end_idle1");

    run_mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
